// File: rtl/uart_pkg.sv
// Shared definitions for the host-side UART receiver.
//   rx_state_t    : receiver FSM state encoding
//   DATA_BITS     : payload bits per frame
//   clks_per_bit  : clk cycles per serial bit (integer divide)
//   parity_of     : XOR reduction of a data byte (1 = odd number of ones)
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   localparam int DATA_BITS = 8;

   function automatic int clks_per_bit(input int sys_clk_freq, input int baud_rate);
      return sys_clk_freq / baud_rate;
   endfunction

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO for uart_rx_host.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and byte; dropped (drop=1) when full and no pop
//   pop        : read request, ignored while empty
//   rdata      : last popped byte, held until the next accepted pop
//   rvalid     : one-cycle pulse the cycle after an accepted pop
//   empty/full : combinational from pointer compare
//   drop       : combinational, push refused this cycle
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int AW = 3,
   parameter int DW = DATA_BITS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          empty,
   output logic          full,
   output logic          drop
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW:0]   wptr_r;
   logic [AW:0]   rptr_r;
   logic [DW-1:0] rdata_r;
   logic          rvalid_r;
   logic          pop_ok_s;
   logic          push_ok_s;

   assign empty = (wptr_r == rptr_r);
   assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);

   // A pop frees a slot in the same cycle, so a push while full still lands
   // when it coincides with an accepted pop.
   assign pop_ok_s  = pop & ~empty;
   assign push_ok_s = push & (~full | pop_ok_s);
   assign drop      = push & ~push_ok_s;

   assign rdata  = rdata_r;
   assign rvalid = rvalid_r;

   // Storage array write port (contents need no reset; pointers define validity).
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wptr_r[AW-1:0]] <= wdata;
      end
   end

   // Pointers and registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r   <= {(AW+1){1'b0}};
         rptr_r   <= {(AW+1){1'b0}};
         rdata_r  <= {DW{1'b0}};
         rvalid_r <= 1'b0;
      end else begin
         rvalid_r <= pop_ok_s;
         if (push_ok_s) begin
            wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rptr_r  <= rptr_r + {{AW{1'b0}}, 1'b1};
            rdata_r <= mem_r[rptr_r[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/uart_rx_host.sv
// Host-side UART receiver: decodes the serial line from riscv_top Tx and
// buffers bytes in a small FIFO drained through a read port.
// Frame: 8N1 LSB first; with UART_RX_PARITY_EN defined, 8E1.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx          : serial input, idle high, asynchronous to clk
//   rd_en       : pop request (ignored while empty)
//   rd_data     : popped byte, valid while rd_valid=1, held afterwards
//   rd_valid    : one-cycle pulse one clk after an accepted rd_en
//   empty, full : FIFO status
//   frame_err   : one-cycle pulse, stop bit sampled low
//   parity_err  : one-cycle pulse, parity mismatch (0 without UART_RX_PARITY_EN)
//   overrun     : sticky, a good byte was dropped on a full FIFO
module uart_rx_host
   import uart_pkg::*;
#(
   parameter int SYS_CLK_FREQ = 100000000,
   parameter int BAUD_RATE    = 115200,
   parameter int FIFO_AW      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       empty,
   output logic       full,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun
);

   localparam int CPB = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] HALF_CNT = CW'(CPB / 2);
   localparam logic [CW-1:0] FULL_CNT = CW'(CPB - 1);
   localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

`ifdef UART_RX_PARITY_EN
   localparam rx_state_t AFTER_DATA = ST_PARITY;
`else
   localparam rx_state_t AFTER_DATA = ST_STOP;
`endif

   logic sync1_r;
   logic sync2_r;
   logic prev_r;
   logic rx_s;
   logic fall_s;

   rx_state_t                state_r;
   rx_state_t                state_s;
   logic [CW-1:0]            cnt_r;
   logic [CW-1:0]            cnt_s;
   logic [2:0]               bit_r;
   logic [2:0]               bit_s;
   logic [DATA_BITS-1:0]     shift_r;
   logic [DATA_BITS-1:0]     shift_s;
   logic                     push_s;
   logic                     ferr_s;
   logic                     frame_err_r;
   logic                     overrun_r;
   logic                     drop_s;
`ifdef UART_RX_PARITY_EN
   logic                     par_r;
   logic                     par_s;
   logic                     perr_s;
   logic                     parity_err_r;
`endif

   // Two-flop synchroniser plus one history flop for start-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= rx;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign rx_s   = sync2_r;
   assign fall_s = prev_r & ~sync2_r;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, sampling and push/error decisions.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r + CW'(1);
      bit_s   = bit_r;
      shift_s = shift_r;
      push_s  = 1'b0;
      ferr_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_s   = par_r;
      perr_s  = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            cnt_s = ZERO_CNT;
            if (fall_s) begin
               state_s = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            // Mid start bit: a high line means the falling edge was a glitch.
            if (cnt_r == HALF_CNT) begin
               cnt_s = ZERO_CNT;
               bit_s = 3'd0;
               if (rx_s) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (cnt_r == FULL_CNT) begin
               cnt_s   = ZERO_CNT;
               shift_s = {rx_s, shift_r[DATA_BITS-1:1]};
               bit_s   = bit_r + 3'd1;
               if (bit_r == 3'd7) begin
                  state_s = AFTER_DATA;
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (cnt_r == FULL_CNT) begin
               cnt_s   = ZERO_CNT;
               par_s   = rx_s;
               state_s = ST_STOP;
            end else begin
               state_s = ST_PARITY;
            end
`else
            state_s = ST_IDLE;
`endif
         end
         ST_STOP: begin
            // Returning to IDLE here lets a start bit that follows the stop
            // bit with no gap be caught.
            if (cnt_r == FULL_CNT) begin
               cnt_s   = ZERO_CNT;
               state_s = ST_IDLE;
               if (!rx_s) begin
                  ferr_s = 1'b1;
               end
`ifdef UART_RX_PARITY_EN
               else if ((parity_of(shift_r) ^ par_r) != 1'b0) begin
                  perr_s = 1'b1;
               end
`endif
               else begin
                  push_s = 1'b1;
               end
            end else begin
               state_s = ST_STOP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = ZERO_CNT;
         end
      endcase
   end

   // Datapath registers, error pulses and sticky overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r        <= ZERO_CNT;
         bit_r        <= 3'd0;
         shift_r      <= {DATA_BITS{1'b0}};
         frame_err_r  <= 1'b0;
         overrun_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_r        <= 1'b0;
         parity_err_r <= 1'b0;
`endif
      end else begin
         cnt_r        <= cnt_s;
         bit_r        <= bit_s;
         shift_r      <= shift_s;
         frame_err_r  <= ferr_s;
         overrun_r    <= overrun_r | drop_s;
`ifdef UART_RX_PARITY_EN
         par_r        <= par_s;
         parity_err_r <= perr_s;
`endif
      end
   end

   assign frame_err = frame_err_r;
   assign overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_r;
`else
   assign parity_err = 1'b0;
`endif

   uart_rx_fifo #(
      .AW (FIFO_AW),
      .DW (DATA_BITS)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push_s),
      .wdata  (shift_r),
      .pop    (rd_en),
      .rdata  (rd_data),
      .rvalid (rd_valid),
      .empty  (empty),
      .full   (full),
      .drop   (drop_s)
   );

endmodule
